// File: rtl/vga_scanout_engine.sv
// VGA scanout core: timing, scaled pixel addressing, frame-latched mode/state,
// mode mux into the palette and delay-matched sync, blank and colour.
module vga_scanout_engine #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int SCALE_SHIFT = 0,
    parameter int ADDR_W      = 19,
    parameter int N_MODES     = 8,
    parameter int N_CH        = 10,
    parameter int IMG_LAT     = 1,
    parameter int PAL_LAT     = 1,
    localparam int MODE_W     = (N_MODES > 1) ? $clog2(N_MODES) : 1
) (
    input  logic                      iVGA_CLK,
    input  logic                      reset,
    input  logic [MODE_W-1:0]         mode_in,
    input  logic [N_CH*32-1:0]        ch_in,
    output logic [N_CH*32-1:0]        ch_frame,
    output logic [MODE_W-1:0]         mode_frame,
    output logic [15:0]               frame_cnt,
    output logic [ADDR_W-1:0]         cur_addr,
    output logic [10:0]               pix_x,
    output logic [9:0]                pix_y,
    input  logic [N_MODES*ADDR_W-1:0] mode_addr_in,
    input  logic [N_MODES*8-1:0]      mode_index_in,
    output logic [ADDR_W-1:0]         addr_imgmem,
    input  logic [7:0]                q_imgmem,
    output logic [7:0]                pal_addr,
    input  logic [23:0]               pal_q,
    output logic                      oHS,
    output logic                      oVS,
    output logic                      oBLANK_n,
    output logic [7:0]                b_data,
    output logic [7:0]                g_data,
    output logic [7:0]                r_data
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int L       = IMG_LAT + PAL_LAT + 1;

    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
    localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0]  VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [ADDR_W-1:0] LINE_W = ADDR_W'(H_ACTIVE >> SCALE_SHIFT);

    logic [10:0]       h, h_n;
    logic [9:0]        v, v_n;
    logic [ADDR_W-1:0] line_base, lb_n, addr_n;
    logic              de, de_n, hs_c, vs_c, fb;
    logic [2:0]        dly [L];
    logic [23:0]       colour;
    logic              unused_q;

    // q_imgmem is consumed by the external per-mode index logic only
    assign unused_q = ^q_imgmem;

    assign de   = (h < H_ACT) && (v < V_ACT);
    assign hs_c = !((h >= HS_BEG) && (h < HS_END));
    assign vs_c = !((v >= VS_BEG) && (v < VS_END));
    assign fb   = (h == 11'd0) && (v == V_ACT);

    // line_base steps by one scaled line width whenever v>>SCALE_SHIFT moves
    always_comb begin
        h_n  = h + 11'd1;
        v_n  = v;
        lb_n = line_base;
        if (h == H_LAST) begin
            h_n = '0;
            if (v == V_LAST) begin
                v_n  = '0;
                lb_n = '0;
            end else begin
                v_n = v + 10'd1;
                if ((v_n >> SCALE_SHIFT) != (v >> SCALE_SHIFT))
                    lb_n = line_base + LINE_W;
            end
        end
        de_n   = (h_n < H_ACT) && (v_n < V_ACT);
        addr_n = lb_n + ADDR_W'(h_n >> SCALE_SHIFT);
    end

    always_ff @(posedge iVGA_CLK or posedge reset) begin
        if (reset) begin
            h         <= '0;
            v         <= '0;
            line_base <= '0;
            cur_addr  <= '0;
            pix_x     <= '0;
            pix_y     <= '0;
        end else begin
            h         <= h_n;
            v         <= v_n;
            line_base <= lb_n;
            if (de_n) begin
                cur_addr <= addr_n;
                pix_x    <= h_n;
                pix_y    <= v_n;
            end
        end
    end

    always_ff @(posedge iVGA_CLK or posedge reset) begin
        if (reset) begin
            mode_frame <= '0;
            ch_frame   <= '0;
            frame_cnt  <= '0;
        end else if (fb) begin
            mode_frame <= mode_in;
            ch_frame   <= ch_in;
            frame_cnt  <= frame_cnt + 16'd1;
        end
    end

    // unknown modes fall back to mode 0
    always_comb begin
        addr_imgmem = mode_addr_in[0 +: ADDR_W];
        pal_addr    = mode_index_in[0 +: 8];
        for (int k = 1; k < N_MODES; k++) begin
            if (int'(mode_frame) == k) begin
                addr_imgmem = mode_addr_in[k*ADDR_W +: ADDR_W];
                pal_addr    = mode_index_in[k*8 +: 8];
            end
        end
    end

    // dly[k] holds {hs, vs, de} delayed k+1 cycles
    always_ff @(posedge iVGA_CLK or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < L; k++)
                dly[k] <= 3'b110;
            colour <= '0;
        end else begin
            dly[0] <= {hs_c, vs_c, de};
            for (int k = 1; k < L; k++)
                dly[k] <= dly[k-1];
            colour <= dly[L-2][0] ? pal_q : 24'd0;
        end
    end

    assign oHS      = dly[L-1][2];
    assign oVS      = dly[L-1][1];
    assign oBLANK_n = dly[L-1][0];
    assign b_data   = colour[23:16];
    assign g_data   = colour[15:8];
    assign r_data   = colour[7:0];

endmodule

// File: tb/tb_vga_scanout_engine.sv
// Directed bench: full-size timing instance plus two small-timing
// instances for frame latching, scaling, latency and reset checks.
module tb_vga_scanout_engine;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [7:0] img_word(input logic [18:0] a);
        return (a == 19'd0) ? 8'd7 : (a[7:0] ^ 8'h5A);
    endfunction

    function automatic logic [23:0] pal_word(input logic [7:0] i);
        logic [7:0] c;
        c = 8'(i * 3);
        return {c, c, c};
    endfunction

    function automatic logic [63:0] chf(input int n);
        logic [31:0] w;
        w = 32'hC0DE0000 + 32'(n / 24);
        return {w, ~w};
    endfunction

    // ---------------- full-size instance ----------------
    logic [319:0] chf_d;
    logic [2:0]   mf_d;
    logic [15:0]  fc_d;
    logic [18:0]  ca_d, ai_d;
    logic [10:0]  px_d;
    logic [9:0]   py_d;
    logic [151:0] ma_d;
    logic [63:0]  mi_d;
    logic [7:0]   q_d, pa_d;
    logic [23:0]  pq_d;
    logic         hs_d, vs_d, bl_d;
    logic [7:0]   b_d, g_d, r_d;

    always_comb begin
        ma_d = '0;
        mi_d = '0;
        for (int k = 0; k < 8; k++) begin
            ma_d[k*19 +: 19] = ca_d + 19'(k * 1000);
            mi_d[k*8 +: 8]   = q_d + 8'(k);
        end
    end

    always @(posedge clk) begin
        q_d  <= img_word(ai_d);
        pq_d <= pal_word(pa_d);
    end

    vga_scanout_engine u_def (
        .iVGA_CLK(clk), .reset(rst), .mode_in(3'd0),
        .ch_in(320'd0), .ch_frame(chf_d), .mode_frame(mf_d),
        .frame_cnt(fc_d), .cur_addr(ca_d), .pix_x(px_d),
        .pix_y(py_d), .mode_addr_in(ma_d), .mode_index_in(mi_d),
        .addr_imgmem(ai_d), .q_imgmem(q_d), .pal_addr(pa_d),
        .pal_q(pq_d), .oHS(hs_d), .oVS(vs_d), .oBLANK_n(bl_d),
        .b_data(b_d), .g_data(g_d), .r_data(r_d)
    );

    // ---------------- small instance, latency 2/2, 5 modes ----------------
    logic [2:0]  mode_s = 3'd0;
    logic [63:0] ch_s   = '0;
    logic [63:0] chf_s;
    logic [2:0]  mf_s;
    logic [15:0] fc_s;
    logic [18:0] ca_s, ai_s;
    logic [10:0] px_s;
    logic [9:0]  py_s;
    logic [94:0] ma_s;
    logic [39:0] mi_s;
    logic [7:0]  q_s, q_s1, pa_s;
    logic [23:0] pq_s, pq_s1;
    logic        hs_s, vs_s, bl_s;
    logic [7:0]  b_s, g_s, r_s;

    always_comb begin
        ma_s = '0;
        mi_s = '0;
        for (int k = 0; k < 5; k++) begin
            ma_s[k*19 +: 19] = ca_s + 19'(k * 1000);
            mi_s[k*8 +: 8]   = q_s + 8'(k);
        end
    end

    always @(posedge clk) begin
        q_s1  <= img_word(ai_s);
        q_s   <= q_s1;
        pq_s1 <= pal_word(pa_s);
        pq_s  <= pq_s1;
    end

    vga_scanout_engine #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .N_MODES(5), .N_CH(2), .IMG_LAT(2), .PAL_LAT(2)
    ) u_sm (
        .iVGA_CLK(clk), .reset(rst), .mode_in(mode_s),
        .ch_in(ch_s), .ch_frame(chf_s), .mode_frame(mf_s),
        .frame_cnt(fc_s), .cur_addr(ca_s), .pix_x(px_s),
        .pix_y(py_s), .mode_addr_in(ma_s), .mode_index_in(mi_s),
        .addr_imgmem(ai_s), .q_imgmem(q_s), .pal_addr(pa_s),
        .pal_q(pq_s), .oHS(hs_s), .oVS(vs_s), .oBLANK_n(bl_s),
        .b_data(b_s), .g_data(g_s), .r_data(r_s)
    );

    // ---------------- small instance, 2x replication ----------------
    logic [319:0] chf_c;
    logic [2:0]   mf_c;
    logic [15:0]  fc_c;
    logic [18:0]  ca_c, ai_c;
    logic [10:0]  px_c;
    logic [9:0]   py_c;
    logic [7:0]   pa_c;
    logic         hs_c, vs_c, bl_c;
    logic [7:0]   b_c, g_c, r_c;

    vga_scanout_engine #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .SCALE_SHIFT(1)
    ) u_sc (
        .iVGA_CLK(clk), .reset(rst), .mode_in(3'd0),
        .ch_in(320'd0), .ch_frame(chf_c), .mode_frame(mf_c),
        .frame_cnt(fc_c), .cur_addr(ca_c), .pix_x(px_c),
        .pix_y(py_c), .mode_addr_in(152'd0), .mode_index_in(64'd0),
        .addr_imgmem(ai_c), .q_imgmem(8'd0), .pal_addr(pa_c),
        .pal_q(24'd0), .oHS(hs_c), .oVS(vs_c), .oBLANK_n(bl_c),
        .b_data(b_c), .g_data(g_c), .r_data(r_c)
    );

    // ---------------- cycle counter and monitors ----------------
    int cyc;
    always @(posedge clk or posedge rst)
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;

    always @(negedge clk) ch_s = chf(cyc);

    int   hs_fall [2];
    int   vs_fall [2];
    int   hs_nf = 0, vs_nf = 0, hs_w = 0, vs_w = 0;
    int   de_line = 0, de_frm = 0, blank_bad = 0;
    logic hs_prev = 1'b1, vs_prev = 1'b1;

    always @(negedge clk) begin
        if (rst) begin
            hs_nf = 0; vs_nf = 0; hs_w = 0; vs_w = 0;
            de_line = 0; de_frm = 0;
            hs_prev = 1'b1; vs_prev = 1'b1;
        end else begin
            if (hs_prev && !hs_d && hs_nf < 2) begin
                hs_fall[hs_nf] = cyc;
                hs_nf++;
            end
            if (!hs_prev && hs_d && hs_w == 0 && hs_nf > 0)
                hs_w = cyc - hs_fall[0];
            if (vs_prev && !vs_s && vs_nf < 2) begin
                vs_fall[vs_nf] = cyc;
                vs_nf++;
            end
            if (!vs_prev && vs_s && vs_w == 0 && vs_nf > 0)
                vs_w = cyc - vs_fall[0];
            if (cyc < 800 && bl_d) de_line++;
            if (cyc < 360 && bl_s) de_frm++;
            if (!bl_d && {b_d, g_d, r_d} != 24'd0) blank_bad++;
            if (!bl_s && {b_s, g_s, r_s} != 24'd0) blank_bad++;
            hs_prev = hs_d;
            vs_prev = vs_s;
        end
    end

    task automatic wait_cyc(input int n);
        int guard = 0;
        while (cyc < n && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        chk("cycle_sync", 64'(cyc), 64'(n));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        repeat (3) @(negedge clk);
        chk("rst_hs",    64'(hs_d), 64'd1);
        chk("rst_vs",    64'(vs_d), 64'd1);
        chk("rst_blank", 64'(bl_d), 64'd0);
        chk("rst_rgb",   64'({b_d, g_d, r_d}), 64'd0);
        chk("rst_addr",  64'(ca_d), 64'd0);
        chk("rst_fcnt",  64'(fc_d), 64'd0);
        chk("rst_chf",   chf_s, 64'd0);
        rst = 1'b0;

        wait_cyc(2);
        chk("def_blank_c2", 64'(bl_d), 64'd0);
        wait_cyc(3);
        chk("def_blank_c3", 64'(bl_d), 64'd1);
        chk("def_first_rgb", 64'({b_d, g_d, r_d}), 64'h151515);
        wait_cyc(4);
        chk("sm_blank_c4", 64'(bl_s), 64'd0);
        wait_cyc(5);
        chk("sm_blank_c5", 64'(bl_s), 64'd1);
        chk("sm_first_rgb", 64'({b_s, g_s, r_s}), 64'h151515);

        wait_cyc(24);
        chk("sc_addr_v1h0", 64'(ca_c), 64'd0);
        wait_cyc(51);
        chk("sc_addr_v2h3", 64'(ca_c), 64'd9);
        wait_cyc(77);
        chk("sc_addr_v3h5", 64'(ca_c), 64'd10);
        chk("sc_pix_x", 64'(px_c), 64'd5);
        chk("sc_pix_y", 64'(py_c), 64'd3);

        wait_cyc(96);
        mode_s = 3'd3;
        wait_cyc(150);
        chk("mode_hold_150", 64'(mf_s), 64'd0);
        wait_cyc(183);
        chk("sc_addr_last", 64'(ca_c), 64'd31);
        wait_cyc(190);
        chk("sc_addr_held", 64'(ca_c), 64'd31);

        wait_cyc(191);
        chk("mode_pre_fb", 64'(mf_s), 64'd0);
        chk("fcnt_pre_fb", 64'(fc_s), 64'd0);
        chk("chf_pre_fb",  chf_s, 64'd0);
        wait_cyc(193);
        chk("mode_post_fb", 64'(mf_s), 64'd3);
        chk("fcnt_post_fb", 64'(fc_s), 64'd1);
        chk("chf_post_fb",  chf_s, chf(192));
        chk("mux_addr_m3",  64'(ai_s), 64'd3127);
        chk("mux_pal_m3",   64'(pa_s), 64'h28);

        wait_cyc(300);
        chk("chf_hold", chf_s, chf(192));
        mode_s = 3'd6;
        wait_cyc(553);
        chk("mode_oob_latch", 64'(mf_s), 64'd6);
        chk("mux_addr_oob",   64'(ai_s), 64'd127);
        chk("fcnt_2",         64'(fc_s), 64'd2);
        chk("chf_frame2",     chf_s, chf(552));

        wait_cyc(1700);
        chk("hs_fall0",   64'(hs_fall[0]), 64'd659);
        chk("hs_period",  64'(hs_fall[1] - hs_fall[0]), 64'd800);
        chk("hs_width",   64'(hs_w), 64'd96);
        chk("de_per_line", 64'(de_line), 64'd640);
        chk("vs_fall0",   64'(vs_fall[0]), 64'd245);
        chk("vs_period",  64'(vs_fall[1] - vs_fall[0]), 64'd360);
        chk("vs_width",   64'(vs_w), 64'd48);
        chk("de_per_frame", 64'(de_frm), 64'd128);
        chk("blank_rgb_zero", 64'(blank_bad), 64'd0);

        wait_cyc(1930);
        chk("pre_rst_blank", 64'(bl_s), 64'd1);
        chk("pre_rst_fcnt",  64'(fc_s), 64'd5);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_blank", 64'(bl_s), 64'd0);
        chk("mid_rst_hs",    64'(hs_s), 64'd1);
        chk("mid_rst_vs",    64'(vs_s), 64'd1);
        chk("mid_rst_rgb",   64'({b_s, g_s, r_s}), 64'd0);
        chk("mid_rst_fcnt",  64'(fc_s), 64'd0);
        chk("mid_rst_mode",  64'(mf_s), 64'd0);
        chk("mid_rst_chf",   chf_s, 64'd0);
        chk("mid_rst_addr",  64'(ca_s), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        wait_cyc(4);
        chk("re_blank_c4", 64'(bl_s), 64'd0);
        wait_cyc(5);
        chk("re_blank_c5", 64'(bl_s), 64'd1);
        chk("re_first_rgb", 64'({b_s, g_s, r_s}), 64'h151515);
        wait_cyc(700);
        chk("re_vs_seen",  64'(vs_nf > 0), 64'd1);
        chk("re_vs_fall0", 64'(vs_fall[0]), 64'd245);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
